// File: rtl/jtdd_pkg.sv
// Shared types and constants for the JTDD ROM request responders.
package jtdd_pkg;

    localparam int SDRAM_AW = 22;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } romrq_state_t;

    // Tags are held at SDRAM address width so any consumer width up to
    // SDRAM_AW fits; narrower addresses are zero-extended before storing.
    typedef struct packed {
        logic                valid;
        logic [SDRAM_AW-1:0] tag;
        logic [15:0]         data;
    } cache_entry_t;

    // SDRAM word address: region offset plus consumer address, wrapping mod 2^SDRAM_AW.
    function automatic logic [SDRAM_AW-1:0] sdram_word(
        input logic [SDRAM_AW-1:0] offset,
        input logic [SDRAM_AW-1:0] addr
    );
        return offset + addr;
    endfunction

endpackage

// File: rtl/jtdd_romrq_cache2.sv
// Two-entry tag store with a 1-bit LRU replacement pointer and hit lookup.
module jtdd_romrq_cache2
    import jtdd_pkg::*;
#(
    parameter int AW = 17
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          cs,
    input  logic [AW-1:0] addr,
    output logic          hit,
    output logic [15:0]   hit_data,
    input  logic          fill,
    input  logic [AW-1:0] fill_addr,
    input  logic [15:0]   fill_data
);

    cache_entry_t        entry [2];
    logic                lru;
    logic [SDRAM_AW-1:0] addr_tag;
    logic [SDRAM_AW-1:0] fill_tag;
    logic                hit0;
    logic                hit1;

    assign addr_tag = SDRAM_AW'(addr);
    assign fill_tag = SDRAM_AW'(fill_addr);
    assign hit0     = entry[0].valid && (entry[0].tag == addr_tag);
    assign hit1     = entry[1].valid && (entry[1].tag == addr_tag);
    assign hit      = cs && !flush && (hit0 || hit1);

    // Select the data of whichever entry matches the current address.
    always_comb begin
        hit_data = '0;
        if (hit1) hit_data = entry[1].data;
        if (hit0) hit_data = entry[0].data;
    end

    // Entry storage and LRU: flush clears valids, fill writes the LRU slot,
    // a hit points LRU at the entry that was not used.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry[0] <= '0;
            entry[1] <= '0;
            lru      <= 1'b0;
        end else if (flush) begin
            entry[0].valid <= 1'b0;
            entry[1].valid <= 1'b0;
        end else if (fill) begin
            entry[lru] <= '{valid: 1'b1, tag: fill_tag, data: fill_data};
            lru        <= ~lru;
        end else if (hit) begin
            lru <= hit0;
        end
    end

endmodule

// File: rtl/jtdd_scr_romrq.sv
// Scroll-layer ROM request responder: 2-entry cache in front of the SDRAM arbiter port.
module jtdd_scr_romrq
    import jtdd_pkg::*;
#(
    parameter int                  AW     = 17,
    parameter logic [SDRAM_AW-1:0] OFFSET = 22'h0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                downloading,
    input  logic [AW-1:0]       rom_addr,
    input  logic                rom_cs,
    output logic [15:0]         rom_data,
    output logic                rom_ok,
    output logic [SDRAM_AW-1:0] sdram_addr,
    output logic                sdram_req,
    input  logic                sdram_ack,
    input  logic                data_rdy,
    input  logic [15:0]         sdram_din
);

    romrq_state_t  state;
    romrq_state_t  state_nxt;
    logic          req_nxt;
    logic          latch;
    logic          fill;
    logic          fill_hit;
    logic [AW-1:0] req_addr;
    logic [AW-1:0] last_addr;
    logic          hit;
    logic          hit_r;
    logic [15:0]   hit_data;

    jtdd_romrq_cache2 #(
        .AW (AW)
    ) u_cache (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (downloading),
        .cs        (rom_cs),
        .addr      (rom_addr),
        .hit       (hit),
        .hit_data  (hit_data),
        .fill      (fill),
        .fill_addr (req_addr),
        .fill_data (sdram_din)
    );

    assign sdram_addr = sdram_word(OFFSET, SDRAM_AW'(req_addr));
    assign rom_ok     = hit_r && (rom_addr == last_addr);

    // A fill for the address still being requested is forwarded straight to
    // the output so rom_ok follows data_rdy by one clock instead of two.
    assign fill_hit = fill && !downloading && rom_cs && (req_addr == rom_addr);

    // Next-state and handshake decode; an acknowledged request always completes.
    always_comb begin
        state_nxt = state;
        req_nxt   = sdram_req;
        latch     = 1'b0;
        fill      = 1'b0;
        case (state)
            IDLE: begin
                if (rom_cs && !hit && !downloading) begin
                    state_nxt = REQ;
                    req_nxt   = 1'b1;
                    latch     = 1'b1;
                end
            end
            REQ: begin
                if (sdram_ack) begin
                    req_nxt = 1'b0;
                    if (data_rdy) begin
                        fill      = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = WAIT;
                    end
                end else if (downloading) begin
                    req_nxt   = 1'b0;
                    state_nxt = IDLE;
                end
            end
            WAIT: begin
                if (data_rdy) begin
                    fill      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                req_nxt   = 1'b0;
            end
        endcase
    end

    // FSM state, request line and latched request address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sdram_req <= 1'b0;
            req_addr  <= '0;
        end else begin
            state     <= state_nxt;
            sdram_req <= req_nxt;
            if (latch) req_addr <= rom_addr;
        end
    end

    // Registered hit flag, output data and the address they belong to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_r     <= 1'b0;
            rom_data  <= '0;
            last_addr <= '0;
        end else begin
            hit_r     <= hit || fill_hit;
            last_addr <= rom_addr;
            if (fill_hit)  rom_data <= sdram_din;
            else if (hit)  rom_data <= hit_data;
        end
    end

endmodule

// File: tb/tb_jtdd_scr_romrq.sv
// Directed self-checking bench for jtdd_scr_romrq.
module tb_jtdd_scr_romrq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        downloading;
    logic [16:0] rom_addr;
    logic        rom_cs;
    logic [15:0] rom_data,   rom_data2;
    logic        rom_ok,     rom_ok2;
    logic [21:0] sdram_addr, sdram_addr2;
    logic        sdram_req,  sdram_req2;
    logic        sdram_ack;
    logic        data_rdy;
    logic [15:0] sdram_din;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    jtdd_scr_romrq #(
        .AW     (17),
        .OFFSET (22'h080000)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .downloading (downloading),
        .rom_addr    (rom_addr),
        .rom_cs      (rom_cs),
        .rom_data    (rom_data),
        .rom_ok      (rom_ok),
        .sdram_addr  (sdram_addr),
        .sdram_req   (sdram_req),
        .sdram_ack   (sdram_ack),
        .data_rdy    (data_rdy),
        .sdram_din   (sdram_din)
    );

    // Offset near the top of the SDRAM space to exercise address wrap.
    jtdd_scr_romrq #(
        .AW     (17),
        .OFFSET (22'h3FFFF0)
    ) dut_wrap (
        .clk         (clk),
        .rst_n       (rst_n),
        .downloading (downloading),
        .rom_addr    (rom_addr),
        .rom_cs      (rom_cs),
        .rom_data    (rom_data2),
        .rom_ok      (rom_ok2),
        .sdram_addr  (sdram_addr2),
        .sdram_req   (sdram_req2),
        .sdram_ack   (sdram_ack),
        .data_rdy    (data_rdy),
        .sdram_din   (sdram_din)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Miss on address a, ack the next cycle, return data d the cycle after.
    task automatic fetch(input logic [16:0] a, input logic [15:0] d);
        rom_addr = a;
        tick();
        check("fetch_req", 32'(sdram_req), 32'd1);
        check("fetch_addr", 32'(sdram_addr), 32'(22'h080000 + 22'(a)));
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
        check("fetch_req_drop", 32'(sdram_req), 32'd0);
        check("fetch_ok_wait", 32'(rom_ok), 32'd0);
        sdram_din = d;
        data_rdy  = 1'b1;
        tick();
        data_rdy  = 1'b0;
        check("fetch_ok", 32'(rom_ok), 32'd1);
        check("fetch_data", 32'(rom_data), 32'(d));
    endtask

    // Move to a cached address: rom_ok must drop at once, then rise with data, no request.
    task automatic hit_check(input logic [16:0] a, input logic [15:0] d);
        rom_addr = a;
        #1;
        check("hit_stale_ok", 32'(rom_ok), 32'd0);
        tick();
        check("hit_ok", 32'(rom_ok), 32'd1);
        check("hit_data", 32'(rom_data), 32'(d));
        check("hit_noreq", 32'(sdram_req), 32'd0);
    endtask

    initial begin
        rst_n       = 1'b0;
        downloading = 1'b0;
        rom_addr    = '0;
        rom_cs      = 1'b0;
        sdram_ack   = 1'b0;
        data_rdy    = 1'b0;
        sdram_din   = '0;
        tick();
        tick();

        // Reset values
        check("rst_ok", 32'(rom_ok), 32'd0);
        check("rst_data", 32'(rom_data), 32'd0);
        check("rst_req", 32'(sdram_req), 32'd0);
        check("rst_addr", 32'(sdram_addr), 32'h080000);
        check("rst_addr_wrap", 32'(sdram_addr2), 32'h3FFFF0);

        // Cold miss with explicit arbiter latency
        rst_n    = 1'b1;
        rom_cs   = 1'b1;
        rom_addr = 17'h00123;
        tick();
        check("cold_req", 32'(sdram_req), 32'd1);
        check("cold_addr", 32'(sdram_addr), 32'h080123);
        check("cold_addr_wrap", 32'(sdram_addr2), 32'h000113);
        tick();
        tick();
        check("cold_req_hold", 32'(sdram_req), 32'd1);
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
        check("cold_req_drop", 32'(sdram_req), 32'd0);
        tick();
        tick();
        check("cold_ok_wait", 32'(rom_ok), 32'd0);
        sdram_din = 16'hBEEF;
        data_rdy  = 1'b1;
        tick();
        data_rdy  = 1'b0;
        check("cold_ok", 32'(rom_ok), 32'd1);
        check("cold_data", 32'(rom_data), 32'hBEEF);
        check("cold_ok_wrap", 32'(rom_ok2), 32'd1);
        check("cold_data_wrap", 32'(rom_data2), 32'hBEEF);

        // Hit reuse
        fetch(17'h00456, 16'h1234);
        hit_check(17'h00123, 16'hBEEF);
        hit_check(17'h00456, 16'h1234);
        hit_check(17'h00123, 16'hBEEF);

        // LRU eviction: A=123 most recent, C replaces B=456
        fetch(17'h00789, 16'h7777);
        hit_check(17'h00123, 16'hBEEF);
        fetch(17'h00456, 16'h5555);

        // Address change mid-fetch
        rom_addr = 17'h00010;
        tick();
        check("mid_req", 32'(sdram_req), 32'd1);
        check("mid_addr", 32'(sdram_addr), 32'h080010);
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
        rom_addr  = 17'h00020;
        #1;
        check("mid_ok0", 32'(rom_ok), 32'd0);
        tick();
        check("mid_ok1", 32'(rom_ok), 32'd0);
        check("mid_req_low", 32'(sdram_req), 32'd0);
        sdram_din = 16'h1010;
        data_rdy  = 1'b1;
        tick();
        data_rdy  = 1'b0;
        check("mid_ok_fill", 32'(rom_ok), 32'd0);
        check("mid_req_fill", 32'(sdram_req), 32'd0);
        tick();
        check("mid_req2", 32'(sdram_req), 32'd1);
        check("mid_addr2", 32'(sdram_addr), 32'h080020);
        check("mid_addr2_wrap", 32'(sdram_addr2), 32'h000010);

        // Same-cycle ack and data
        sdram_ack = 1'b1;
        data_rdy  = 1'b1;
        sdram_din = 16'h2020;
        tick();
        sdram_ack = 1'b0;
        data_rdy  = 1'b0;
        check("same_ok", 32'(rom_ok), 32'd1);
        check("same_data", 32'(rom_data), 32'h2020);
        check("same_req", 32'(sdram_req), 32'd0);
        hit_check(17'h00010, 16'h1010);

        // Download withdraws the request and flushes the cache
        rom_addr = 17'h00030;
        tick();
        check("dl_req", 32'(sdram_req), 32'd1);
        downloading = 1'b1;
        tick();
        check("dl_withdraw", 32'(sdram_req), 32'd0);
        check("dl_ok", 32'(rom_ok), 32'd0);
        downloading = 1'b0;
        rom_addr    = 17'h00010;
        tick();
        check("dl_flushed_req", 32'(sdram_req), 32'd1);
        check("dl_flushed_ok", 32'(rom_ok), 32'd0);
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;

        // Reset in WAIT
        #2;
        rst_n = 1'b0;
        #1;
        check("rstw_ok", 32'(rom_ok), 32'd0);
        check("rstw_req", 32'(sdram_req), 32'd0);
        check("rstw_addr", 32'(sdram_addr), 32'h080000);
        rst_n     = 1'b1;
        sdram_din = 16'hDEAD;
        data_rdy  = 1'b1;
        tick();
        data_rdy  = 1'b0;
        check("rstw_stray_ok", 32'(rom_ok), 32'd0);
        check("rstw_miss_req", 32'(sdram_req), 32'd1);

        // Reset in REQ drops the request asynchronously
        #2;
        rst_n = 1'b0;
        #1;
        check("rstr_req", 32'(sdram_req), 32'd0);
        rst_n = 1'b1;
        tick();
        check("rstr_req_again", 32'(sdram_req), 32'd1);
        sdram_ack = 1'b1;
        data_rdy  = 1'b1;
        sdram_din = 16'hABCD;
        tick();
        sdram_ack = 1'b0;
        data_rdy  = 1'b0;
        check("rstr_ok", 32'(rom_ok), 32'd1);
        check("rstr_data", 32'(rom_data), 32'hABCD);

        // Reset while rom_ok is high
        #2;
        rst_n = 1'b0;
        #1;
        check("rsth_ok", 32'(rom_ok), 32'd0);
        check("rsth_data", 32'(rom_data), 32'd0);
        rst_n = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
